matrix_vec_mul_fx: RTL

//  Parametrised fixed-point matrix x vector engine: N*N matrix plus N-vector loaded via we/addr/data_wr,

---
 rtl/matrix_vec_mul_fx_pkg.sv | 22 ++
 rtl/matrix_vec_mul_fx_normalize.sv | 41 ++++
 rtl/matrix_vec_mul_fx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/matrix_vec_mul_fx_pkg.sv
// rtl/matrix_vec_mul_fx_pkg.sv - shared defaults, FSM encoding and width helpers
package matrix_vec_mul_fx_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int ADDRS_LEN_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_NORM = 2'd2
  } state_t;

  // Wide enough that N full-scale products can never overflow.
  function automatic int acc_width(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

  function automatic int q_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/matrix_vec_mul_fx_normalize.sv
// rtl/matrix_vec_mul_fx_normalize.sv - fx_normalize: leading-sign count, shift and saturate
module fx_normalize #(
  parameter int AW = 35,
  parameter int W  = 16,
  parameter int F  = 16,
  parameter int QW = 4
) (
  input  logic signed [AW-1:0] acc_i,
  output logic signed [W-1:0]  data_o,
  output logic [QW-1:0]        qi_o,
  output logic [QW-1:0]        qf_o
);

  int  red;
  int  k;
  int  qf;
  logic run;

  always_comb begin
    red = 0;
    run = 1'b1;
    for (int i = AW - 2; i >= 0; i--) begin
      if (run && (acc_i[i] == acc_i[AW-1])) red = red + 1;
      else run = 1'b0;
    end
    // Integer bits the value actually needs, sign excluded, never below zero.
    k = (AW - red) - 1 - F;
    if (k < 0) k = 0;
    qf = W - 1 - k;
    if (qf > F) qf = F;
    data_o = W'(acc_i >>> (F - qf));
    qf_o   = qf[QW-1:0];
    qi_o   = QW'(W - 1 - qf);
    if (k > W - 1) begin
      data_o = acc_i[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      qi_o   = QW'(W - 1);
      qf_o   = '0;
    end
  end

endmodule

// File: rtl/matrix_vec_mul_fx.sv
// rtl/matrix_vec_mul_fx.sv - N x N fixed-point matrix-vector engine, one MAC per cycle
module matrix_vec_mul_fx
  import matrix_vec_mul_fx_pkg::*;
#(
  parameter int N         = 8,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int IN_QF     = 8,
  parameter int ADDRS_LEN = ADDRS_LEN_DEF,
  parameter int QW        = q_width(WORD_SIZE)
) (
  input  logic                        src_clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ADDRS_LEN-1:0]        addr,
  input  logic signed [WORD_SIZE-1:0] data_wr,
  input  logic                        start,
  output logic                        busy,
  output logic                        out_valid,
  output logic signed [WORD_SIZE-1:0] out_data,
  output logic [QW-1:0]               out_qi,
  output logic [QW-1:0]               out_qf,
  output logic                        out_last
);

  localparam int AW = acc_width(N, WORD_SIZE);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic signed [WORD_SIZE-1:0] mat_q [N][N];
  logic signed [WORD_SIZE-1:0] vec_q [N];

  state_t                      state_q, state_d;
  logic [CW-1:0]               row_q, row_d, col_q, col_d;
  logic signed [AW-1:0]        acc_q, acc_d;
  logic                        valid_q, valid_d, last_q, last_d;
  logic signed [WORD_SIZE-1:0] data_q, data_d;
  logic [QW-1:0]               qi_q, qi_d, qf_q, qf_d;

  logic signed [2*WORD_SIZE-1:0] prod;
  logic signed [WORD_SIZE-1:0]   norm_data;
  logic [QW-1:0]                 norm_qi, norm_qf;
  logic                          idle_free;

  // The out_last cycle still counts as busy, so writes/start wait one more cycle.
  assign idle_free = (state_q == ST_IDLE) && !last_q;
  assign busy      = (state_q != ST_IDLE) || last_q;
  assign prod      = mat_q[row_q][col_q] * vec_q[col_q];

  always_ff @(posedge src_clk) begin
    if (we && idle_free) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (addr == ADDRS_LEN'(r * N + c)) mat_q[r][c] <= data_wr;
        end
      end
      for (int c = 0; c < N; c++) begin
        if (addr == ADDRS_LEN'(N * N + c)) vec_q[c] <= data_wr;
      end
    end
  end

  fx_normalize #(
    .AW (AW),
    .W  (WORD_SIZE),
    .F  (2 * IN_QF),
    .QW (QW)
  ) u_norm (
    .acc_i  (acc_q),
    .data_o (norm_data),
    .qi_o   (norm_qi),
    .qf_o   (norm_qf)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    data_d  = data_q;
    qi_d    = qi_q;
    qf_d    = qf_q;
    case (state_q)
      ST_IDLE: begin
        if (start && idle_free) begin
          state_d = ST_MAC;
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + AW'(prod);
        if (col_q == LAST) state_d = ST_NORM;
        else col_d = col_q + 1'b1;
      end
      ST_NORM: begin
        data_d  = norm_data;
        qi_d    = norm_qi;
        qf_d    = norm_qf;
        valid_d = 1'b1;
        last_d  = (row_q == LAST);
        acc_d   = '0;
        col_d   = '0;
        if (row_q == LAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MAC;
          row_d   = row_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      qi_q    <= '0;
      qf_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      qi_q    <= qi_d;
      qf_q    <= qf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_data  = data_q;
  assign out_qi    = qi_q;
  assign out_qf    = qf_q;

endmodule
